// File: rtl/rtc_snapshot_sequencer.sv
// Reads DS1302 sec..year plus a seconds re-read, then publishes a coherent BCD
// snapshot in a single cycle; retries when seconds rolled over, aborts on driver stall.
module rtc_snapshot_sequencer #(
  parameter int POLL_CYCLES    = 12_500_000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int RETRY_MAX      = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       req,
  output logic [7:0] rtc_addr,
  output logic       rtc_valid,
  input  logic       rtc_busy,
  input  logic       rtc_done,
  input  logic [7:0] rtc_rdata,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] date,
  output logic [7:0] month,
  output logic [7:0] year,
  output logic       clock_halt,
  output logic       time_valid,
  output logic       seq_busy,
  output logic [1:0] err
);

  localparam int PCW = $clog2(POLL_CYCLES);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RCW = $clog2(RETRY_MAX + 2);
  localparam logic [PCW-1:0] POLL_LAST  = PCW'(POLL_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [RCW-1:0] RETRY_LAST = RCW'(RETRY_MAX);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_PUBLISH = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [RCW-1:0]  retry_q, retry_d;
  logic [TCW-1:0]  tmo_q, tmo_d;
  logic [PCW-1:0]  poll_q, poll_d;
  logic            pend_q, pend_d;
  logic [5:0][7:0] shadow_q, shadow_d;
  logic [6:0]      resec_q, resec_d;
  logic [7:0]      addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [5:0][7:0] snap_q, snap_d;
  logic            ch_q, ch_d;
  logic            tv_q, tv_d;
  logic [1:0]      err_q, err_d;
  logic            take;
  logic            poll_wrap;

  // Index 6 is the seconds re-read; day-of-week (0x8B) is skipped on purpose.
  function automatic logic [7:0] cmd_addr(input logic [2:0] i);
    case (i)
      3'd1:    return 8'h83;
      3'd2:    return 8'h85;
      3'd3:    return 8'h87;
      3'd4:    return 8'h89;
      3'd5:    return 8'h8D;
      default: return 8'h81;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    shadow_d  = shadow_q;
    resec_d   = resec_q;
    addr_d    = addr_q;
    valid_d   = 1'b0;
    snap_d    = snap_q;
    ch_d      = ch_q;
    tv_d      = 1'b0;
    err_d     = err_q;
    take      = 1'b0;
    poll_d    = poll_q;
    pend_d    = pend_q;
    poll_wrap = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          take    = 1'b1;
          idx_d   = 3'd0;
          retry_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!rtc_busy) begin
          addr_d  = cmd_addr(idx_q);
          valid_d = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // done is tested first so a done on the last allowed cycle is accepted
        if (rtc_done) begin
          if (idx_q == 3'd6) begin
            resec_d = rtc_rdata[6:0];
            state_d = S_CHECK;
          end else begin
            for (int i = 0; i < 6; i++) begin
              if (idx_q == 3'(i)) shadow_d[i] = rtc_rdata;
            end
            idx_d   = idx_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d[0] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + TCW'(1);
        end
      end
      S_CHECK: begin
        if (shadow_q[0][6:0] == resec_q) begin
          state_d = S_PUBLISH;
        end else if (retry_q < RETRY_LAST) begin
          retry_d = retry_q + RCW'(1);
          idx_d   = 3'd0;
          state_d = S_ISSUE;
        end else begin
          err_d[1] = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_PUBLISH: begin
        snap_d       = shadow_q;
        snap_d[0][7] = 1'b0;
        ch_d         = shadow_q[0][7];
        tv_d         = 1'b1;
        err_d        = 2'b00;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Triggers arriving while a request is pending or running collapse into one.
    if (!enable) begin
      poll_d = '0;
      pend_d = 1'b0;
    end else begin
      poll_wrap = (poll_q == POLL_LAST);
      poll_d    = poll_wrap ? '0 : poll_q + PCW'(1);
      pend_d    = (pend_q & ~take) | poll_wrap | req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      retry_q  <= '0;
      tmo_q    <= '0;
      poll_q   <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      resec_q  <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      snap_q   <= '0;
      ch_q     <= 1'b0;
      tv_q     <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      poll_q   <= poll_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      resec_q  <= resec_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      snap_q   <= snap_d;
      ch_q     <= ch_d;
      tv_q     <= tv_d;
      err_q    <= err_d;
    end
  end

  assign rtc_addr   = addr_q;
  assign rtc_valid  = valid_q;
  assign sec        = snap_q[0];
  assign min        = snap_q[1];
  assign hour       = snap_q[2];
  assign date       = snap_q[3];
  assign month      = snap_q[4];
  assign year       = snap_q[5];
  assign clock_halt = ch_q;
  assign time_valid = tv_q;
  assign seq_busy   = (state_q != S_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_rtc_snapshot_sequencer.sv
// Bench for rtc_snapshot_sequencer: scripted/random DS1302 driver responses are
// scored against a pass-level model of the snapshot, retry and error rules.
module tb_rtc_snapshot_sequencer;
  localparam int POLL  = 200;
  localparam int TMO   = 40;
  localparam int RETRY = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic       req = 1'b0;
  logic       rtc_busy = 1'b0;
  logic       rtc_done = 1'b0;
  logic [7:0] rtc_rdata = 8'h00;
  logic [7:0] rtc_addr, sec, min, hour, date, month, year;
  logic       rtc_valid, clock_halt, time_valid, seq_busy;
  logic [1:0] err;

  rtc_snapshot_sequencer #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO), .RETRY_MAX(RETRY)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .req(req),
    .rtc_addr(rtc_addr), .rtc_valid(rtc_valid), .rtc_busy(rtc_busy),
    .rtc_done(rtc_done), .rtc_rdata(rtc_rdata),
    .sec(sec), .min(min), .hour(hour), .date(date), .month(month), .year(year),
    .clock_halt(clock_halt), .time_valid(time_valid), .seq_busy(seq_busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] cmd_tbl [7] = '{8'h81, 8'h83, 8'h85, 8'h87, 8'h89, 8'h8D, 8'h81};

  // Driver model state and observation logs
  logic [7:0] resp_q[$];
  logic [7:0] addr_log[$];
  int         rises[$];
  bit         drv_stall = 1'b0;
  int         lat_ovr = -1;
  int         lat_max = 0;
  int         cyc = 0;
  int         tv_cnt = 0;
  int         valid_dbl = 0;
  int         last_cmd_cyc = 0;
  int         last_fall = 0;
  bit         busy_prev = 1'b0;
  bit         valid_prev = 1'b0;

  // Expected state
  logic [47:0] e_snap = '0;
  logic        e_ch = 1'b0;
  logic [1:0]  e_err = 2'b00;
  int          e_ncmd = 0;
  bit          e_pub = 1'b0;
  int          tv0 = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (time_valid === 1'b1) tv_cnt++;
    if (seq_busy && !busy_prev) rises.push_back(cyc);
    if (!seq_busy && busy_prev) last_fall = cyc;
    if (rtc_valid && valid_prev) valid_dbl++;
    busy_prev  = seq_busy;
    valid_prev = rtc_valid;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rtc_valid === 1'b1) begin
        logic [7:0] d;
        int lat;
        addr_log.push_back(rtc_addr);
        last_cmd_cyc = cyc;
        if (!drv_stall) begin
          d = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h11;
          lat = (lat_ovr >= 0) ? lat_ovr : int'($urandom_range(lat_max, 0));
          lat_ovr = -1;
          repeat (lat) @(negedge clk);
          rtc_rdata = d;
          rtc_done  = 1'b1;
          @(negedge clk);
          rtc_done  = 1'b0;
        end
      end
    end
  end

  // Pass-level model: each pass is seven reads; the first pass whose two seconds
  // reads agree (ignoring CH) is published, otherwise incoherence after RETRY+1 passes.
  task automatic model_seq();
    int k;
    e_pub  = 1'b0;
    e_ncmd = 0;
    for (int p = 0; p <= RETRY; p++) begin
      k = p * 7;
      e_ncmd += 7;
      if ((resp_q[k] & 8'h7F) == (resp_q[k+6] & 8'h7F)) begin
        e_snap = {resp_q[k] & 8'h7F, resp_q[k+1], resp_q[k+2], resp_q[k+3], resp_q[k+4], resp_q[k+5]};
        e_ch   = resp_q[k][7];
        e_err  = 2'b00;
        e_pub  = 1'b1;
        break;
      end
    end
    if (!e_pub) e_err = e_err | 2'b10;
  endtask

  task automatic push_pass(input logic [7:0] s0, mi, h, d, mo, y, s6);
    resp_q.push_back(s0); resp_q.push_back(mi); resp_q.push_back(h);
    resp_q.push_back(d);  resp_q.push_back(mo); resp_q.push_back(y);
    resp_q.push_back(s6);
  endtask

  task automatic begin_seq(input bit expect_tmo);
    addr_log.delete();
    tv0 = tv_cnt;
    if (expect_tmo) begin
      e_ncmd = 1;
      e_pub  = 1'b0;
      e_err  = e_err | 2'b01;
    end else begin
      model_seq();
    end
  endtask

  task automatic kick();
    @(negedge clk); enable = 1'b0;
    @(negedge clk); enable = 1'b1; req = 1'b1;
    @(negedge clk); req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!seq_busy && n < budget) begin @(negedge clk); n++; end
    while (seq_busy && n < budget) begin @(negedge clk); n++; end
    chk({tag, ":finished"}, seq_busy, 1'b0);
  endtask

  task automatic end_seq(input string tag);
    wait_done(tag, 400);
    repeat (3) @(negedge clk);
    chk({tag, ":ncmd"}, addr_log.size(), e_ncmd);
    for (int i = 0; i < addr_log.size() && i < e_ncmd; i++)
      chk({tag, ":addr"}, addr_log[i], cmd_tbl[i % 7]);
    chk({tag, ":tvcount"}, tv_cnt - tv0, e_pub);
    chk({tag, ":snap"}, {sec, min, hour, date, month, year}, e_snap);
    chk({tag, ":ch"}, clock_halt, e_ch);
    chk({tag, ":err"}, err, e_err);
    chk({tag, ":idle"}, seq_busy, 1'b0);
    enable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbad, c0, n;
    logic [7:0] s0, s6;

    #2 reset_n = 1'b0;
    #1 chk("reset:outs", {rtc_addr, rtc_valid, sec, min, hour, date, month, year,
                          clock_halt, time_valid, seq_busy, err}, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // req without enable and stray done in IDLE are ignored
    addr_log.delete();
    @(negedge clk); req = 1'b1; rtc_rdata = 8'hFF; rtc_done = 1'b1;
    @(negedge clk); req = 1'b0; rtc_done = 1'b0;
    repeat (10) @(negedge clk);
    chk("noen:cmds", addr_log.size(), 0);
    chk("noen:busy", seq_busy, 1'b0);
    chk("noen:tv", tv_cnt, 0);

    resp_q.delete();
    push_pass(8'h45, 8'h30, 8'h12, 8'h25, 8'h12, 8'h23, 8'h45);
    begin_seq(0); kick(); end_seq("basic");

    resp_q.delete();
    push_pass(8'hC5, 8'h59, 8'h92, 8'h31, 8'h01, 8'h99, 8'hC5);
    begin_seq(0); kick(); end_seq("halt");

    resp_q.delete();
    for (int p = 0; p <= RETRY; p++) push_pass(8'h59, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00);
    begin_seq(0); kick(); end_seq("incoh");

    resp_q.delete();
    push_pass(8'h59, 8'h10, 8'h11, 8'h12, 8'h07, 8'h24, 8'h00);
    push_pass(8'h00, 8'h11, 8'h11, 8'h12, 8'h07, 8'h24, 8'h00);
    begin_seq(0); kick(); end_seq("retry1");

    resp_q.delete();
    drv_stall = 1'b1;
    begin_seq(1); kick(); end_seq("stall");
    chk("stall:cycles", last_fall - last_cmd_cyc, TMO);
    drv_stall = 1'b0;

    resp_q.delete();
    push_pass(8'h33, 8'h44, 8'h55, 8'h16, 8'h08, 8'h42, 8'h33);
    lat_ovr = TMO - 1;
    begin_seq(0); kick(); end_seq("donewins");

    resp_q.delete();
    push_pass(8'h21, 8'h22, 8'h23, 8'h24, 8'h05, 8'h26, 8'h21);
    lat_ovr = TMO;
    begin_seq(1); kick(); end_seq("late");
    resp_q.delete();

    push_pass(8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h08);
    begin_seq(0);
    @(negedge clk); rtc_busy = 1'b1;
    kick();
    repeat (50) @(negedge clk);
    chk("busy:nocmd", addr_log.size(), 0);
    chk("busy:seqbusy", seq_busy, 1'b1);
    rtc_busy = 1'b0;
    end_seq("busy");

    // Periodic polling, then two reqs during one sequence
    resp_q.delete();
    @(negedge clk); enable = 1'b0; rises.delete(); tv0 = tv_cnt;
    @(negedge clk); enable = 1'b1; c0 = cyc;
    n = 0;
    while (rises.size() < 3 && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    n = 0;
    while (rises.size() < 5 && n < 1000) begin @(negedge clk); n++; end
    chk("poll:first", rises[0] - c0, POLL + 1);
    chk("poll:period1", rises[1] - rises[0], POLL);
    chk("poll:period2", rises[2] - rises[1], POLL);
    chk("poll:extra", (rises[3] > rises[2]) && (rises[3] - rises[2] < POLL), 1'b1);
    chk("poll:next", rises[4] - rises[2], POLL);
    enable = 1'b0;
    wait_done("poll", 400);
    repeat (3) @(negedge clk);
    e_snap = {6{8'h11}}; e_ch = 1'b0; e_err = 2'b00;
    chk("poll:tvcount", tv_cnt - tv0, 5);
    chk("poll:snap", {sec, min, hour, date, month, year}, e_snap);

    for (int t = 0; t < 25; t++) begin
      nbad = $urandom_range(RETRY + 1, 0);
      resp_q.delete();
      for (int p = 0; p <= RETRY; p++) begin
        s0 = 8'($urandom);
        if (p < nbad) s6 = s0 ^ (8'd1 << $urandom_range(6, 0));
        else          s6 = {s0[7] ^ 1'($urandom), s0[6:0]};
        push_pass(s0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), s6);
        if (p >= nbad) break;
      end
      lat_max = 3;
      begin_seq(0); kick(); end_seq("rand");
    end
    lat_max = 0;

    // Reset in the middle of a stalled WAIT
    resp_q.delete();
    drv_stall = 1'b1;
    addr_log.delete();
    kick();
    repeat (5) @(negedge clk);
    chk("rst:precond", rtc_addr, 8'h81);
    #2 reset_n = 1'b0;
    #1 chk("rst:outs", {rtc_addr, rtc_valid, sec, min, hour, date, month, year,
                        clock_halt, time_valid, seq_busy, err}, 64'd0);
    @(negedge clk); reset_n = 1'b1; drv_stall = 1'b0;
    addr_log.delete(); tv0 = tv_cnt;
    repeat (20) @(negedge clk);
    chk("rst:idle", seq_busy, 1'b0);
    chk("rst:nocmd", addr_log.size(), 0);
    chk("rst:notv", tv_cnt - tv0, 0);
    enable = 1'b0;

    chk("valid:onecycle", valid_dbl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
